// File: rtl/led_pkg.sv
// Shared state encoding, script entry layout and idle output levels
// for the LED mode sequencer.
package led_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   // Flag positions counted from the top of the duration field
   localparam int LAST_BIT  = 3;
   localparam int PAUSE_BIT = 2;
   localparam int FAST_BIT  = 1;
   localparam int RT_BIT    = 0;
   localparam int DUR_LSB   = 0;

   localparam logic IDLE_PAUSE = 1'b1;
   localparam logic IDLE_FAST  = 1'b0;
   localparam logic IDLE_RT    = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled and flags
// the wrap cycle; a synchronous clear parks it at zero.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] WRAP = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == WRAP) ? '0 : cnt + PW'(1);
      end
   end

   assign tick = en && (cnt == WRAP);

endmodule

// File: rtl/led_mode_sequencer.sv
// Scripted pause/fast/rt driver for rotate_led: plays a table of
// timed mode steps, optionally looping, with start/stop control.
module led_mode_sequencer
   import led_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int DUR_W    = 8,
   parameter int TICK_DIV = 50000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DUR_W+3:0]         wr_data,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     loop_en,
   output logic                     pause,
   output logic                     fast,
   output logic                     rt,
   output logic [$clog2(DEPTH)-1:0] step_idx,
   output logic                     busy,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

   logic [DUR_W+3:0] script_mem [DEPTH];

   state_t           state;
   state_t           state_n;
   logic [AW-1:0]    step_n;
   logic [3:0]       act;
   logic [3:0]       act_n;
   logic [DUR_W-1:0] dur_cnt;
   logic [DUR_W-1:0] dur_n;
   logic [DUR_W-1:0] rd_dur;
   logic [3:0]       rd_flags;
   logic             pause_n;
   logic             fast_n;
   logic             rt_n;
   logic             tick;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         script_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_dur   = script_mem[step_idx][DUR_LSB +: DUR_W];
   assign rd_flags = script_mem[step_idx][DUR_W +: 4];

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (state_n != RUN),
      .en    (state == RUN),
      .tick  (tick)
   );

   always_comb begin
      state_n = state;
      step_n  = step_idx;
      act_n   = act;
      dur_n   = dur_cnt;
      if (stop) begin
         state_n = IDLE;
         step_n  = '0;
      end else if (start) begin
         state_n = LOAD;
         step_n  = '0;
      end else begin
         unique case (state)
            IDLE: begin
            end
            LOAD: begin
               state_n = RUN;
               act_n   = rd_flags;
               dur_n   = (rd_dur == '0) ? DUR_ONE : rd_dur;
            end
            RUN: begin
               if (tick) begin
                  if (dur_cnt > DUR_ONE) begin
                     dur_n = dur_cnt - DUR_ONE;
                  end else begin
                     dur_n = '0;
                     if (!act[LAST_BIT] && step_idx != LAST_IDX) begin
                        step_n  = step_idx + AW'(1);
                        state_n = LOAD;
                     end else if (loop_en) begin
                        step_n  = '0;
                        state_n = LOAD;
                     end else begin
                        state_n = DONE;
                     end
                  end
               end
            end
            DONE: begin
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end

      // Outputs are registered from the state being entered
      pause_n = pause;
      fast_n  = fast;
      rt_n    = rt;
      unique case (state_n)
         IDLE: begin
            pause_n = IDLE_PAUSE;
            fast_n  = IDLE_FAST;
            rt_n    = IDLE_RT;
         end
         LOAD: begin
         end
         RUN: begin
            pause_n = act_n[PAUSE_BIT];
            fast_n  = act_n[FAST_BIT];
            rt_n    = act_n[RT_BIT];
         end
         DONE: begin
            pause_n = 1'b1;
            fast_n  = act_n[FAST_BIT];
            rt_n    = act_n[RT_BIT];
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         step_idx <= '0;
         act      <= '0;
         dur_cnt  <= '0;
         pause    <= IDLE_PAUSE;
         fast     <= IDLE_FAST;
         rt       <= IDLE_RT;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         step_idx <= step_n;
         act      <= act_n;
         dur_cnt  <= dur_n;
         pause    <= pause_n;
         fast     <= fast_n;
         rt       <= rt_n;
         busy     <= (state_n == LOAD) || (state_n == RUN);
         done     <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: cycle-level reference model compared
// every cycle, directed scenarios with literal timing expectations.
module tb_led_mode_sequencer;

   localparam int DEPTH = 8;
   localparam int DUR_W = 8;
   localparam int TDIV  = 4;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [11:0] wr_data;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic        pause;
   logic        fast;
   logic        rt;
   logic [2:0]  step_idx;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   led_mode_sequencer #(
      .DEPTH    (DEPTH),
      .DUR_W    (DUR_W),
      .TICK_DIV (TDIV)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .start    (start),
      .stop     (stop),
      .loop_en  (loop_en),
      .pause    (pause),
      .fast     (fast),
      .rt       (rt),
      .step_idx (step_idx),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase 0 idle, 1 load, 2 run, 3 done.
   // A run phase simply lasts max(dur,1)*TDIV clock cycles.
   typedef struct packed {
      logic       last;
      logic       p;
      logic       f;
      logic       r;
      logic [7:0] dur;
   } ent_t;

   ent_t mem [DEPTH];
   ent_t cur;
   int   ph = 0;
   int   mstep = 0;
   int   run_left = 0;
   bit   mvalid = 0;
   logic ep = 1'b1;
   logic ef = 1'b0;
   logic er = 1'b1;

   always @(posedge clk) begin
      if (!reset) begin
         ph     = 0;
         mstep  = 0;
         ep     = 1'b1;
         ef     = 1'b0;
         er     = 1'b1;
         mvalid = 1;
      end else begin
         if (stop) begin
            ph    = 0;
            mstep = 0;
         end else if (start) begin
            ph    = 1;
            mstep = 0;
         end else if (ph == 1) begin
            cur      = mem[mstep];
            run_left = ((cur.dur == 0) ? 1 : int'(cur.dur)) * TDIV;
            ph       = 2;
         end else if (ph == 2) begin
            run_left--;
            if (run_left == 0) begin
               if (!cur.last && mstep < DEPTH - 1) begin
                  mstep++;
                  ph = 1;
               end else if (loop_en) begin
                  mstep = 0;
                  ph    = 1;
               end else begin
                  ph = 3;
               end
            end
         end
         case (ph)
            0: {ep, ef, er} = 3'b101;
            2: {ep, ef, er} = {cur.p, cur.f, cur.r};
            3: {ep, ef, er} = {1'b1, cur.f, cur.r};
            default: ;
         endcase
      end
      if (wr_en) mem[wr_addr] = wr_data;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         logic eb;
         logic ed;
         eb = (ph == 1) || (ph == 2);
         ed = (ph == 3);
         checks++;
         if ({pause, fast, rt, busy, done} !== {ep, ef, er, eb, ed} ||
             step_idx !== 3'(mstep)) begin
            errors++;
            $display("FAIL model t=%0t got pfr=%b%b%b b=%b d=%b s=%0d exp pfr=%b%b%b b=%b d=%b s=%0d",
                     $time, pause, fast, rt, busy, done, step_idx,
                     ep, ef, er, eb, ed, mstep);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", nm, got, exp);
      end
   endtask

   function automatic logic [11:0] ent(input bit l, input bit p,
                                       input bit f, input bit r,
                                       input int d);
      return {l, p, f, r, 8'(d)};
   endfunction

   task automatic write_entry(input int a, input logic [11:0] d);
      wr_addr = 3'(a);
      wr_data = d;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic wait_step(input int idx, input string nm);
      int n = 0;
      while (!(busy === 1'b1 && step_idx === 3'(idx)) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s timeout waiting for step %0d", nm, idx);
      end
   endtask

   // Samples {busy,pause,fast,rt,step_idx} from now until busy drops
   logic [6:0] smp [256];
   int         nsmp;

   task automatic profile(input string nm);
      nsmp = 0;
      while (busy === 1'b1 && nsmp < 250) begin
         smp[nsmp] = {busy, pause, fast, rt, step_idx};
         nsmp++;
         @(negedge clk);
      end
      if (nsmp >= 250) begin
         checks++;
         errors++;
         $display("FAIL %s timeout busy=%b exp 0", nm, busy);
      end
   endtask

   function automatic int count_pfr(input logic [2:0] v);
      int c = 0;
      for (int i = 0; i < nsmp; i++) if (smp[i][5:3] == v) c++;
      return c;
   endfunction

   function automatic int count_step(input int s);
      int c = 0;
      for (int i = 0; i < nsmp; i++) if (smp[i][2:0] == 3'(s)) c++;
      return c;
   endfunction

   function automatic int max_step();
      int m = 0;
      for (int i = 0; i < nsmp; i++) if (int'(smp[i][2:0]) > m) m = smp[i][2:0];
      return m;
   endfunction

   initial begin
      reset   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      start   = 1'b0;
      stop    = 1'b0;
      loop_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("reset_pfr", {pause, fast, rt}, 3'b101);
      check("reset_step", step_idx, 0);
      check("reset_busy_done", {busy, done}, 2'b00);

      write_entry(0, ent(0, 0, 1, 1, 2));
      write_entry(1, ent(0, 0, 0, 0, 1));
      write_entry(2, ent(1, 1, 1, 1, 3));
      for (int i = 3; i < DEPTH; i++) write_entry(i, ent(0, 0, 0, 1, 1));
      check("idle_after_writes", {pause, fast, rt, busy, done}, 5'b10100);

      // Three-step script, no loop: 8 + 1 + 4 + 1 + 12 busy cycles
      // after the initial LOAD; LOAD keeps the previous mode visible.
      pulse_start();
      profile("script3");
      check("s3_load_view", smp[0], {1'b1, 3'b101, 3'd0});
      check("s3_first_run", smp[1][5:3], 3'b011);
      check("s3_busy_len", nsmp, 27);
      check("s3_n011", count_pfr(3'b011), 9);
      check("s3_n000", count_pfr(3'b000), 5);
      check("s3_n111", count_pfr(3'b111), 12);
      check("s3_step0", count_step(0), 9);
      check("s3_step1", count_step(1), 5);
      check("s3_step2", count_step(2), 13);
      check("s3_done", {done, busy, pause, fast, rt}, 5'b10111);

      loop_en = 1'b1;
      pulse_start();
      wait_step(2, "loop_a");
      wait_step(0, "loop_b");
      @(negedge clk);
      check("loop_step0_mode", {pause, fast, rt, step_idx}, {3'b011, 3'd0});
      pulse_stop();
      check("stop_idle", {pause, fast, rt, busy, done, step_idx},
            {3'b101, 2'b00, 3'd0});

      pulse_start();
      repeat (2) @(negedge clk);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check("start_stop_idle", {pause, fast, rt, busy}, 4'b1010);

      pulse_start();
      wait_step(2, "restart");
      @(negedge clk);
      pulse_start();
      check("restart_load0", {busy, step_idx, pause, fast, rt},
            {1'b1, 3'd0, 3'b111});
      pulse_stop();

      pulse_start();
      wait_step(1, "ovw_a");
      @(negedge clk);
      check("ovw_before", {pause, fast, rt}, 3'b000);
      write_entry(1, ent(0, 1, 0, 1, 1));
      check("ovw_unchanged", {pause, fast, rt}, 3'b000);
      wait_step(2, "ovw_b");
      wait_step(1, "ovw_c");
      @(negedge clk);
      check("ovw_new_mode", {pause, fast, rt}, 3'b101);
      pulse_stop();

      // dur=0 runs for exactly one tick
      loop_en = 1'b0;
      write_entry(0, ent(1, 0, 1, 0, 0));
      pulse_start();
      profile("dur0");
      check("dur0_busy_len", nsmp, 5);
      check("dur0_run_mode", count_pfr(3'b010), 4);
      check("dur0_done", {done, pause, fast, rt}, 4'b1110);

      for (int i = 0; i < DEPTH; i++) write_entry(i, ent(0, 0, 0, 1, 1));
      pulse_start();
      profile("nolast");
      check("nolast_busy_len", nsmp, 40);
      check("nolast_max_step", max_step(), 7);
      check("nolast_done", {done, step_idx}, {1'b1, 3'd7});

      for (int c = 0; c < 3000; c++) begin
         wr_en   = ($urandom_range(7) == 0);
         wr_addr = 3'($urandom_range(7));
         wr_data = ent($urandom_range(3) == 0, $urandom_range(1) == 1,
                       $urandom_range(1) == 1, $urandom_range(1) == 1,
                       $urandom_range(3));
         start   = ($urandom_range(39) == 0);
         stop    = ($urandom_range(149) == 0);
         if ($urandom_range(49) == 0) loop_en = ~loop_en;
         @(negedge clk);
      end
      wr_en = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
